// File: rtl/sprite_pkg.sv
// Shared configuration encodings, default geometry and index-width helper
// for the sprite scan unit and its per-sprite hit units.
package sprite_pkg;

   typedef enum logic [1:0] {
      CFG_X    = 2'd0,
      CFG_Y    = 2'd1,
      CFG_EN   = 2'd2,
      CFG_RSVD = 2'd3
   } cfg_field_e;

   localparam int DEF_COORD_W   = 10;
   localparam int DEF_SIZE_LOG2 = 4;

   // Width of a sprite slot index; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sprite_hit_unit.sv
// One sprite slot: position/enable registers plus the wrap-around offset
// compare against the current raster position.
module sprite_hit_unit
   import sprite_pkg::*;
#(
   parameter int COORD_W   = DEF_COORD_W,
   parameter int SIZE_LOG2 = DEF_SIZE_LOG2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [COORD_W-1:0]   raster_x,
   input  logic [COORD_W-1:0]   raster_y,
   input  logic                 cfg_sel,
   input  cfg_field_e           cfg_field,
   input  logic [COORD_W-1:0]   cfg_data,
   output logic                 hit,
   output logic [SIZE_LOG2-1:0] dx_low,
   output logic [SIZE_LOG2-1:0] dy_low
);

   logic [COORD_W-1:0] pos_x;
   logic [COORD_W-1:0] pos_y;
   logic               enable;
   logic [COORD_W-1:0] dx;
   logic [COORD_W-1:0] dy;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pos_x  <= '0;
         pos_y  <= '0;
         enable <= 1'b0;
      end else if (cfg_sel) begin
         case (cfg_field)
            CFG_X:   pos_x  <= cfg_data;
            CFG_Y:   pos_y  <= cfg_data;
            CFG_EN:  enable <= cfg_data[0];
            default: ;
         endcase
      end
   end

   // Modulo subtraction lets sprites straddle the coordinate wrap.
   assign dx     = raster_x - pos_x;
   assign dy     = raster_y - pos_y;
   assign hit    = enable && (dx[COORD_W-1:SIZE_LOG2] == '0) && (dy[COORD_W-1:SIZE_LOG2] == '0);
   assign dx_low = dx[SIZE_LOG2-1:0];
   assign dy_low = dy[SIZE_LOG2-1:0];

endmodule

// File: rtl/sprite_scan_unit.sv
// Multi-sprite hit detector: two-stage pipeline to the sprite pixel memory.
// Define SPRITE_COLLISION_EN to build the sticky sprite-overlap collision flag.
module sprite_scan_unit
   import sprite_pkg::*;
#(
   parameter int NUM_SPRITES = 8,
   parameter int SIZE_LOG2   = DEF_SIZE_LOG2,
   parameter int COORD_W     = DEF_COORD_W
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic [COORD_W-1:0]                  raster_x,
   input  logic [COORD_W-1:0]                  raster_y,
   input  logic                                cfg_write,
   input  logic [idx_width(NUM_SPRITES)-1:0]   cfg_sprite,
   input  logic [1:0]                          cfg_field,
   input  logic [COORD_W-1:0]                  cfg_data,
   input  logic                                collision_clear,
   output logic                                sprite_active,
   output logic [idx_width(NUM_SPRITES)-1:0]   sprite_index,
   output logic [2*SIZE_LOG2-1:0]              sprite_address,
   output logic                                collision
);

   localparam int IDX_W = idx_width(NUM_SPRITES);

   logic [NUM_SPRITES-1:0]                hit_now;
   logic [NUM_SPRITES-1:0][SIZE_LOG2-1:0] dx_now;
   logic [NUM_SPRITES-1:0][SIZE_LOG2-1:0] dy_now;
   logic [NUM_SPRITES-1:0]                s1_hits;
   logic [NUM_SPRITES-1:0][SIZE_LOG2-1:0] s1_dx;
   logic [NUM_SPRITES-1:0][SIZE_LOG2-1:0] s1_dy;
   logic                                  win_found;
   logic [IDX_W-1:0]                      win_idx;
   logic [2*SIZE_LOG2-1:0]                win_addr;

   // Slots beyond NUM_SPRITES have no hit unit, so such writes fall away.
   for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_sprite
      sprite_hit_unit #(
         .COORD_W   (COORD_W),
         .SIZE_LOG2 (SIZE_LOG2)
      ) u_hit (
         .clk       (clk),
         .reset_n   (reset_n),
         .raster_x  (raster_x),
         .raster_y  (raster_y),
         .cfg_sel   (cfg_write && (cfg_sprite == IDX_W'(i))),
         .cfg_field (cfg_field_e'(cfg_field)),
         .cfg_data  (cfg_data),
         .hit       (hit_now[i]),
         .dx_low    (dx_now[i]),
         .dy_low    (dy_now[i])
      );
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_hits <= '0;
         s1_dx   <= '0;
         s1_dy   <= '0;
      end else begin
         s1_hits <= hit_now;
         s1_dx   <= dx_now;
         s1_dy   <= dy_now;
      end
   end

   // Lowest index wins; index and address stay zero when nothing hits.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      win_addr  = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         if (!win_found && s1_hits[i]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(i);
            win_addr  = {s1_dy[i], s1_dx[i]};
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sprite_active  <= 1'b0;
         sprite_index   <= '0;
         sprite_address <= '0;
      end else begin
         sprite_active  <= win_found;
         sprite_index   <= win_idx;
         sprite_address <= win_addr;
      end
   end

`ifdef SPRITE_COLLISION_EN
   logic multi_hit;

   // Clearing the lowest set bit leaves something only when two or more hit.
   assign multi_hit = |(s1_hits & (s1_hits - NUM_SPRITES'(1)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         collision <= 1'b0;
      else if (multi_hit)
         collision <= 1'b1;
      else if (collision_clear)
         collision <= 1'b0;
   end
`else
   logic unused_collision_clear;

   assign unused_collision_clear = collision_clear;
   assign collision              = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_scan_unit.sv
// Bench for sprite_scan_unit: directed vector table, hand-written collision/reset
// sequences and random traffic against a pixel-level reference model.
module tb_sprite_scan_unit;

   localparam int NS = 6;
   localparam int SL = 4;
   localparam int CW = 10;
   localparam int IW = 3;
   localparam int SPAN = 1 << CW;
   localparam int EDGE = 1 << SL;

`ifdef SPRITE_COLLISION_EN
   localparam logic EXP_COLL = 1'b1;
`else
   localparam logic EXP_COLL = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset_n;
   logic [CW-1:0]   raster_x;
   logic [CW-1:0]   raster_y;
   logic            cfg_write;
   logic [IW-1:0]   cfg_sprite;
   logic [1:0]      cfg_field;
   logic [CW-1:0]   cfg_data;
   logic            collision_clear;
   logic            sprite_active;
   logic [IW-1:0]   sprite_index;
   logic [2*SL-1:0] sprite_address;
   logic            collision;

   always #5 clk = ~clk;

   sprite_scan_unit #(
      .NUM_SPRITES (NS),
      .SIZE_LOG2   (SL),
      .COORD_W     (CW)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .raster_x        (raster_x),
      .raster_y        (raster_y),
      .cfg_write       (cfg_write),
      .cfg_sprite      (cfg_sprite),
      .cfg_field       (cfg_field),
      .cfg_data        (cfg_data),
      .collision_clear (collision_clear),
      .sprite_active   (sprite_active),
      .sprite_index    (sprite_index),
      .sprite_address  (sprite_address),
      .collision       (collision)
   );

   typedef struct {
      logic            act;
      logic [IW-1:0]   idx;
      logic [2*SL-1:0] addr;
      logic            multi;
      logic            hchk;
      logic            hact;
      logic [IW-1:0]   hidx;
      logic [2*SL-1:0] haddr;
   } exp_t;

   typedef struct {
      logic            wr;
      logic [IW-1:0]   spr;
      logic [1:0]      fld;
      logic [CW-1:0]   data;
      int              x;
      int              y;
      logic            chk;
      logic            act;
      logic [IW-1:0]   idx;
      logic [2*SL-1:0] addr;
   } vec_t;

   int   mx[NS];
   int   my[NS];
   bit   men[NS];
   exp_t st1;
   exp_t st2;
   logic mcoll;
   int   errors = 0;
   int   checks = 0;
   vec_t vecs[22];

   function automatic exp_t zeroExp();
      exp_t r;
      r.act = 1'b0; r.idx = '0; r.addr = '0; r.multi = 1'b0;
      r.hchk = 1'b0; r.hact = 1'b0; r.hidx = '0; r.haddr = '0;
      return r;
   endfunction

   function automatic void resetModel();
      for (int i = 0; i < NS; i++) begin
         mx[i] = 0; my[i] = 0; men[i] = 1'b0;
      end
      st1   = zeroExp();
      st2   = zeroExp();
      mcoll = 1'b0;
   endfunction

   // Which sprites cover pixel (x,y), counted on the wrapped coordinate circle.
   function automatic exp_t modelPixel(input int x, input int y);
      exp_t r;
      int   n;
      int   dx;
      int   dy;
      r = zeroExp();
      n = 0;
      for (int i = 0; i < NS; i++) begin
         dx = (x - mx[i] + SPAN) % SPAN;
         dy = (y - my[i] + SPAN) % SPAN;
         if (men[i] && dx < EDGE && dy < EDGE) begin
            n++;
            if (n == 1) begin
               r.act  = 1'b1;
               r.idx  = IW'(i);
               r.addr = (2*SL)'(dy * EDGE + dx);
            end
         end
      end
      r.multi = (n >= 2);
      return r;
   endfunction

   function automatic vec_t mk(input logic wr, input int spr, input int fld, input int data,
                               input int x, input int y, input logic chk, input logic act,
                               input int idx, input int addr);
      vec_t v;
      v.wr = wr; v.spr = IW'(spr); v.fld = 2'(fld); v.data = CW'(data);
      v.x = x; v.y = y; v.chk = chk; v.act = act; v.idx = IW'(idx); v.addr = (2*SL)'(addr);
      return v;
   endfunction

   task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkOutput();
      checkValue("active", 32'(sprite_active), 32'(st2.act));
      checkValue("index", 32'(sprite_index), 32'(st2.idx));
      checkValue("address", 32'(sprite_address), 32'(st2.addr));
      checkValue("collision", 32'(collision), 32'(mcoll));
      if (st2.hchk) begin
         checkValue("vec_active", 32'(sprite_active), 32'(st2.hact));
         checkValue("vec_index", 32'(sprite_index), 32'(st2.hidx));
         checkValue("vec_address", 32'(sprite_address), 32'(st2.haddr));
      end
   endtask

   // Drive one pixel (plus optional config write) from a negedge and check the
   // outputs that become visible one clock later.
   task automatic applyStimulus(input logic wr, input logic [IW-1:0] spr, input logic [1:0] fld,
                                input logic [CW-1:0] data, input int x, input int y, input logic clr,
                                input logic chk, input logic hact, input logic [IW-1:0] hidx,
                                input logic [2*SL-1:0] haddr);
      exp_t r;
      cfg_write       = wr;
      cfg_sprite      = spr;
      cfg_field       = fld;
      cfg_data        = data;
      raster_x        = CW'(x);
      raster_y        = CW'(y);
      collision_clear = clr;
      r       = modelPixel(x, y);
      r.hchk  = chk;
      r.hact  = hact;
      r.hidx  = hidx;
      r.haddr = haddr;
      if (wr && int'(spr) < NS) begin
         case (fld)
            2'd0:    mx[spr] = int'(data);
            2'd1:    my[spr] = int'(data);
            2'd2:    men[spr] = data[0];
            default: ;
         endcase
      end
      @(posedge clk);
`ifdef SPRITE_COLLISION_EN
      if (st1.multi)
         mcoll = 1'b1;
      else if (clr)
         mcoll = 1'b0;
`endif
      st2 = st1;
      st1 = r;
      @(negedge clk);
      checkOutput();
   endtask

   task automatic idle(input logic clr);
      applyStimulus(1'b0, '0, 2'd0, '0, 600, 400, clr, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic pixel(input int x, input int y);
      applyStimulus(1'b0, '0, 2'd0, '0, x, y, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      reset_n = 1'b0; raster_x = '0; raster_y = '0; cfg_write = 1'b0; cfg_sprite = '0;
      cfg_field = '0; cfg_data = '0; collision_clear = 1'b0;
      resetModel();

      vecs[0]  = mk(1, 2, 0, 100,  600, 400, 0, 0, 0, 0);
      vecs[1]  = mk(1, 2, 1, 50,   600, 400, 0, 0, 0, 0);
      vecs[2]  = mk(1, 2, 2, 1,    600, 400, 0, 0, 0, 0);
      vecs[3]  = mk(0, 0, 0, 0,    105, 53,  1, 1, 2, 'h35);
      vecs[4]  = mk(0, 0, 0, 0,    116, 53,  1, 0, 0, 0);
      vecs[5]  = mk(1, 1, 0, 200,  600, 400, 0, 0, 0, 0);
      vecs[6]  = mk(1, 1, 1, 200,  600, 400, 0, 0, 0, 0);
      vecs[7]  = mk(1, 1, 2, 1,    600, 400, 0, 0, 0, 0);
      vecs[8]  = mk(1, 3, 0, 200,  600, 400, 0, 0, 0, 0);
      vecs[9]  = mk(1, 3, 1, 200,  600, 400, 0, 0, 0, 0);
      vecs[10] = mk(1, 3, 2, 1,    600, 400, 0, 0, 0, 0);
      vecs[11] = mk(0, 0, 0, 0,    207, 201, 1, 1, 1, 'h17);
      vecs[12] = mk(1, 0, 0, 1020, 600, 400, 0, 0, 0, 0);
      vecs[13] = mk(1, 0, 1, 0,    600, 400, 0, 0, 0, 0);
      vecs[14] = mk(1, 0, 2, 1,    600, 400, 0, 0, 0, 0);
      vecs[15] = mk(0, 0, 0, 0,    3,   0,   1, 1, 0, 'h07);
      vecs[16] = mk(1, 0, 0, 300,  300, 0,   1, 0, 0, 0);
      vecs[17] = mk(0, 0, 0, 0,    300, 0,   1, 1, 0, 'h00);
      vecs[18] = mk(1, 0, 3, 0,    300, 0,   1, 1, 0, 'h00);
      vecs[19] = mk(1, 6, 0, 0,    305, 2,   1, 1, 0, 'h25);
      vecs[20] = mk(1, 7, 2, 0,    305, 2,   1, 1, 0, 'h25);
      vecs[21] = mk(0, 0, 0, 0,    305, 2,   1, 1, 0, 'h25);

      @(negedge clk);
      checkValue("reset_active", 32'(sprite_active), 32'd0);
      checkValue("reset_index", 32'(sprite_index), 32'd0);
      checkValue("reset_address", 32'(sprite_address), 32'd0);
      checkValue("reset_collision", 32'(collision), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      $display("[TB] scanning with all sprites disabled");
      for (int y = 0; y < 480; y += 37)
         for (int x = 0; x < 640; x += 5)
            pixel(x, y);

      $display("[TB] directed vector table");
      for (int i = 0; i < 22; i++)
         applyStimulus(vecs[i].wr, vecs[i].spr, vecs[i].fld, vecs[i].data, vecs[i].x, vecs[i].y,
                       1'b0, vecs[i].chk, vecs[i].act, vecs[i].idx, vecs[i].addr);
      idle(1'b0);
      idle(1'b0);

      $display("[TB] collision sticky / clear / set-wins");
      idle(1'b0);
      checkValue("coll_sticky", 32'(collision), 32'(EXP_COLL));
      idle(1'b1);
      checkValue("coll_cleared", 32'(collision), 32'd0);
      pixel(207, 201);
      idle(1'b1);
      checkValue("coll_set_wins", 32'(collision), 32'(EXP_COLL));
      idle(1'b1);
      checkValue("coll_clear_again", 32'(collision), 32'd0);

      $display("[TB] reset while active");
      pixel(105, 53);
      idle(1'b0);
      checkValue("pre_reset_active", 32'(sprite_active), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      checkValue("midreset_active", 32'(sprite_active), 32'd0);
      checkValue("midreset_index", 32'(sprite_index), 32'd0);
      checkValue("midreset_address", 32'(sprite_address), 32'd0);
      checkValue("midreset_collision", 32'(collision), 32'd0);
      resetModel();
      @(negedge clk);
      reset_n = 1'b1;
      pixel(105, 53);
      pixel(207, 201);
      pixel(3, 0);
      pixel(300, 0);
      idle(1'b0);
      checkValue("post_reset_active", 32'(sprite_active), 32'd0);

      $display("[TB] random traffic");
      for (int n = 0; n < 1500; n++) begin
         logic          wr;
         logic [IW-1:0] spr;
         logic [1:0]    fld;
         logic [CW-1:0] data;
         int            x;
         int            y;
         wr   = ($urandom_range(0, 2) == 0);
         spr  = IW'($urandom_range(0, 7));
         fld  = 2'($urandom_range(0, 3));
         data = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(1000, 1023)) : CW'($urandom_range(0, 60));
         x    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1010, 1023)) : int'($urandom_range(0, 80));
         y    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1010, 1023)) : int'($urandom_range(0, 80));
         applyStimulus(wr, spr, fld, data, x, y, ($urandom_range(0, 7) == 0), 1'b0, 1'b0, '0, '0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
